axi4_sram_slave: RTL and testbench
==================================

# axi4_sram_slave

AXI4 slave memory model that sits directly downstream of the core's `io_master` port and serves its instruction-fetch and load/store traffic in simulation. It has independent read and write channel state machines, supports single-beat and INCR/FIXED bursts on a 64-bit data bus, applies a programmable first-beat read latency, and returns DECERR for accesses outside its window. The storage array is 1R1W, so reads and writes proceed concurrently.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 64, data width; strobe width is DATA_WIDTH/8.
- `DEPTH`, 4096, number of 64-bit words.
- `BASE_ADDR`, 32'h8000_0000, first byte address of the window.
- `RD_LATENCY`, 2, idle cycles between the AR handshake and the first R beat (0 allowed).

Ports:
- `clk_i` in 1: single clock; all logic on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `awvalid_i`/`awready_o` in/out 1: AW handshake.
- `awid_i` in 4; `awaddr_i` in ADDR_WIDTH; `awlen_i` in 8; `awsize_i` in 3; `awburst_i` in 2.
- `wvalid_i`/`wready_o` in/out 1: W handshake.
- `wdata_i` in DATA_WIDTH; `wstrb_i` in DATA_WIDTH/8; `wlast_i` in 1.
- `bvalid_o`/`bready_i` out/in 1: B handshake.
- `bid_o` out 4; `bresp_o` out 2.
- `arvalid_i`/`arready_o` in/out 1: AR handshake.
- `arid_i` in 4; `araddr_i` in ADDR_WIDTH; `arlen_i` in 8; `arsize_i` in 3; `arburst_i` in 2.
- `rvalid_o`/`rready_i` out/in 1: R handshake.
- `rid_o` out 4; `rdata_o` out DATA_WIDTH; `rresp_o` out 2; `rlast_o` out 1.

## Operation
- Word index = (addr − BASE_ADDR) >> 3. An address is in range iff BASE_ADDR ≤ addr < BASE_ADDR + DEPTH*8.
- Read FSM states:
  - R_IDLE: `arready_o`=1. An AR handshake latches id, addr, len, size and burst, clears the beat counter, loads the latency counter with RD_LATENCY, then goes to R_WAIT, or directly to R_DATA when RD_LATENCY=0.
  - R_WAIT: counts down; enters R_DATA when the counter reaches 0.
  - R_DATA: `rvalid_o`=1. `rdata_o` is a combinational read of mem[index(cur_addr)], or 0 when out of range. `rlast_o` = (beat == len). On each R handshake, beat++ and the address advances. Handshake with rlast → R_IDLE.
- Address advance: INCR adds (1 << size); FIXED holds the address.
  - WRAP or reserved burst types respond SLVERR (2'b10) on every beat, with data 0.
  - size > 3 also responds SLVERR on every beat.
- Narrow transfers always return the full aligned 64-bit word; the master selects the byte lanes.
- Write FSM states:
  - W_IDLE: `awready_o`=1. An AW handshake latches id, addr, len, size and burst, clears the beat counter and the error flags, then → W_DATA.
  - W_DATA: `wready_o`=1. Each W handshake writes the bytes enabled by `wstrb_i` to mem[index] when the address is in range and the burst is legal. The address advances by the read rules. An out-of-range beat sets the decerr flag and performs no write.
  - W_DATA, on a handshake with `wlast_i`=1 → W_RESP. If `wlast_i` disagrees with (beat == len), the slverr flag is set; the burst still ends only on `wlast_i`.
  - W_RESP: `bvalid_o`=1. `bresp_o` = DECERR (2'b11) if decerr, else SLVERR if slverr or the burst is illegal, else OKAY. Handshake → W_IDLE.
- W beats presented while in W_IDLE are not accepted (`wready_o`=0).
- Same-cycle read and write to the same word: the read returns the old data, and the new data is visible from the next cycle.
- The memory array is not cleared by reset.

## Timing
- Outputs in the cycle after `rst_i` is asserted:
  - `arready_o`=1, `awready_o`=1.
  - `wready_o`, `rvalid_o`, `bvalid_o`, `rlast_o`=0.
  - `rdata_o`=0, `rresp_o`=0, `bresp_o`=0, `rid_o`=0, `bid_o`=0.
- Reset mid-burst abandons the transaction. Writes already performed persist.
- AR handshake in cycle N → first `rvalid_o` in cycle N+1+RD_LATENCY. Later beats come one per cycle while `rready_i`=1.
- `rvalid_o` is held, with stable data, until accepted. `arready_o`=0 from N+1 until the cycle after the last R handshake.
- AW handshake in cycle N → `wready_o`=1 from N+1. Throughput is one W beat per cycle.
- Last W handshake in cycle M → `bvalid_o`=1 in M+1, held until `bready_i`. `awready_o` returns to 1 the cycle after the B handshake.
- The beat counter is 8 bits and len ≤ 255, so the counter never wraps within a burst.

## Test plan
- Reset, then single write: AW addr 0x8000_0010, len 0, W data 0x1122334455667788, strb 0xFF → bvalid one cycle after W, bresp 0, bid = awid.
- Read back (RD_LATENCY=2): AR 0x8000_0010, len 0, id 5 at cycle N → rvalid at N+3, rdata 0x1122334455667788, rlast 1, rid 5, rresp 0.
- INCR burst: write 4 beats (len 3) starting at 0x8000_0100, then read them back with rready toggling 1/0 → 4 beats in order, rlast only on beat 4, data stable while stalled.
- Partial strobe: write strb 0x0F with data 0xAAAAAAAA_BBBBBBBB over 0x1122334455667788 → readback 0x11223344_BBBBBBBB.
- Out of range: read 0x7FFF_FFF8 → rresp 2'b11, rdata 0. Write 0x8000_8000 (DEPTH 4096) → bresp 2'b11 and no memory word changes.
- Protocol errors:
  - WRAP read → SLVERR on every beat.
  - Write burst with awlen 1 but wlast on beat 0 → bresp 2'b10.
  - Reset asserted mid read burst → rvalid 0 next cycle and arready 1.

Source files
------------

// File: rtl/axi4_sram_slave.sv
// AXI4 slave memory model: independent read/write FSMs over a 1R1W word array,
// INCR/FIXED bursts, programmable first-beat read latency, DECERR outside the window.
module axi4_sram_slave #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned           RD_LATENCY = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [3:0]              awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [7:0]              awlen_i,
  input  logic [2:0]              awsize_i,
  input  logic [1:0]              awburst_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic [3:0]              bid_o,
  output logic [1:0]              bresp_o,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  input  logic [3:0]              arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [7:0]              arlen_i,
  input  logic [2:0]              arsize_i,
  input  logic [1:0]              arburst_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [3:0]              rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] LimitAddr =
      {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH * StrbW);
  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [1:0] RespSlv   = 2'b10;
  localparam logic [1:0] RespDec   = 2'b11;

  typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  r_state_e              r_state_q, r_state_d;
  logic [3:0]            r_id_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q, r_beat_q, r_lat_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_burst_q;

  w_state_e              w_state_q, w_state_d;
  logic [3:0]            w_id_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q, w_beat_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q;
  logic                  w_decerr_q, w_slverr_q;

  logic                  ar_hs, r_hs, aw_hs, w_hs;
  logic                  r_in_range, r_illegal, r_last, w_in_range, w_illegal;
  logic [ADDR_WIDTH-1:0] r_off, w_off, r_addr_next, w_addr_next;
  logic [IdxW-1:0]       r_idx, w_idx;
  logic                  unused_off;

  // Address decode and advance, shared rules for both channels
  assign r_off       = r_addr_q - BASE_ADDR;
  assign w_off       = w_addr_q - BASE_ADDR;
  assign r_idx       = r_off[IdxW+OffW-1:OffW];
  assign w_idx       = w_off[IdxW+OffW-1:OffW];
  assign unused_off  = ^{r_off[ADDR_WIDTH-1:IdxW+OffW], r_off[OffW-1:0],
                         w_off[ADDR_WIDTH-1:IdxW+OffW], w_off[OffW-1:0]};
  assign r_in_range  = (r_addr_q >= BASE_ADDR) && ({1'b0, r_addr_q} < LimitAddr);
  assign w_in_range  = (w_addr_q >= BASE_ADDR) && ({1'b0, w_addr_q} < LimitAddr);
  assign r_illegal   = r_burst_q[1] || (r_size_q > 3'(OffW));
  assign w_illegal   = w_burst_q[1] || (w_size_q > 3'(OffW));
  assign r_addr_next = (r_burst_q == BurstIncr) ? r_addr_q + (ADDR_WIDTH'(1) << r_size_q)
                                                : r_addr_q;
  assign w_addr_next = (w_burst_q == BurstIncr) ? w_addr_q + (ADDR_WIDTH'(1) << w_size_q)
                                                : w_addr_q;
  assign r_last      = (r_beat_q == r_len_q);

  assign ar_hs = arvalid_i && arready_o;
  assign r_hs  = rvalid_o && rready_i;
  assign aw_hs = awvalid_i && awready_o;
  assign w_hs  = wvalid_i && wready_o;

  // Read FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state_q <= RIdle;
    else       r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (arvalid_i) r_state_d = (RD_LATENCY == 0) ? RData : RWait;
      RWait:   if (r_lat_q <= 8'd1) r_state_d = RData;
      RData:   if (rready_i && r_last) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    arready_o = 1'b0;
    rvalid_o  = 1'b0;
    rid_o     = '0;
    rdata_o   = '0;
    rresp_o   = '0;
    rlast_o   = 1'b0;
    unique case (r_state_q)
      RIdle: arready_o = 1'b1;
      RData: begin
        rvalid_o = 1'b1;
        rid_o    = r_id_q;
        rlast_o  = r_last;
        if (!r_in_range)    rresp_o = RespDec;
        else if (r_illegal) rresp_o = RespSlv;
        else                rdata_o = mem[r_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_beat_q  <= '0;
      r_lat_q   <= '0;
    end else if (ar_hs) begin
      r_id_q    <= arid_i;
      r_addr_q  <= araddr_i;
      r_len_q   <= arlen_i;
      r_size_q  <= arsize_i;
      r_burst_q <= arburst_i;
      r_beat_q  <= '0;
      r_lat_q   <= 8'(RD_LATENCY);
    end else if (r_state_q == RWait) begin
      r_lat_q <= r_lat_q - 8'd1;
    end else if (r_hs) begin
      r_beat_q <= r_beat_q + 8'd1;
      r_addr_q <= r_addr_next;
    end
  end

  // Write FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) w_state_q <= WIdle;
    else       w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (awvalid_i) w_state_d = WData;
      WData:   if (wvalid_i && wlast_i) w_state_d = WResp;
      WResp:   if (bready_i) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    bid_o     = '0;
    bresp_o   = '0;
    unique case (w_state_q)
      WIdle: awready_o = 1'b1;
      WData: wready_o  = 1'b1;
      WResp: begin
        bvalid_o = 1'b1;
        bid_o    = w_id_q;
        if (w_decerr_q)                    bresp_o = RespDec;
        else if (w_slverr_q || w_illegal)  bresp_o = RespSlv;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_size_q   <= '0;
      w_burst_q  <= '0;
      w_beat_q   <= '0;
      w_decerr_q <= 1'b0;
      w_slverr_q <= 1'b0;
    end else if (aw_hs) begin
      w_id_q     <= awid_i;
      w_addr_q   <= awaddr_i;
      w_len_q    <= awlen_i;
      w_size_q   <= awsize_i;
      w_burst_q  <= awburst_i;
      w_beat_q   <= '0;
      w_decerr_q <= 1'b0;
      w_slverr_q <= 1'b0;
    end else if (w_hs) begin
      w_beat_q <= w_beat_q + 8'd1;
      w_addr_q <= w_addr_next;
      if (!w_in_range) w_decerr_q <= 1'b1;
      if (wlast_i != (w_beat_q == w_len_q)) w_slverr_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset; a beat coinciding with reset is dropped
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_hs && w_in_range && !w_illegal) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (wstrb_i[b]) mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: directed bursts queue expected R/B responses,
// an independent monitor compares them as the DUT presents them.
module tb_axi4_sram_slave;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        awvalid_i, awready_o;
  logic [3:0]  awid_i;
  logic [31:0] awaddr_i;
  logic [7:0]  awlen_i;
  logic [2:0]  awsize_i;
  logic [1:0]  awburst_i;
  logic        wvalid_i, wready_o;
  logic [63:0] wdata_i;
  logic [7:0]  wstrb_i;
  logic        wlast_i;
  logic        bvalid_o, bready_i;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        arvalid_i, arready_o;
  logic [3:0]  arid_i;
  logic [31:0] araddr_i;
  logic [7:0]  arlen_i;
  logic [2:0]  arsize_i;
  logic [1:0]  arburst_i;
  logic        rvalid_o, rready_i;
  logic [3:0]  rid_o;
  logic [63:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;

  axi4_sram_slave dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awid_i(awid_i), .awaddr_i(awaddr_i),
    .awlen_i(awlen_i), .awsize_i(awsize_i), .awburst_i(awburst_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .wlast_i(wlast_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bid_o(bid_o), .bresp_o(bresp_o),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .arid_i(arid_i), .araddr_i(araddr_i),
    .arlen_i(arlen_i), .arsize_i(arsize_i), .arburst_i(arburst_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rid_o(rid_o), .rdata_o(rdata_o),
    .rresp_o(rresp_o), .rlast_o(rlast_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t      exp_r[$];
  b_exp_t      exp_b[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] wbuf [8];

  localparam logic [1:0]  Fixed = 2'b00, Incr = 2'b01, Wrap = 2'b10;
  localparam logic [63:0] A0 = 64'h0123_4567_89AB_CDEF, A1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] A2 = 64'h0F0F_0F0F_F0F0_F0F0, A3 = 64'h5555_AAAA_3333_CCCC;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_r(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp,
                        input logic last);
    r_exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    exp_r.push_back(e);
  endtask

  // Monitor: compares each R/B handshake against the scoreboard, and R stability on stalls
  initial begin
    r_exp_t      re;
    b_exp_t      be;
    logic        r_stalled;
    logic [63:0] r_hold;
    r_stalled = 1'b0;
    r_hold    = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        r_stalled = 1'b0;
      end else begin
        if (rvalid_o) begin
          if (r_stalled) check("r_stable", rdata_o, r_hold);
          if (rready_i) begin
            r_stalled = 1'b0;
            if (exp_r.size() == 0) begin
              check("r_unexpected", 1'b1, 1'b0);
            end else begin
              re = exp_r.pop_front();
              check("rid", rid_o, re.id);
              check("rdata", rdata_o, re.data);
              check("rresp", rresp_o, re.resp);
              check("rlast", rlast_o, re.last);
            end
          end else begin
            r_stalled = 1'b1;
            r_hold    = rdata_o;
          end
        end else begin
          r_stalled = 1'b0;
        end
        if (bvalid_o && bready_i) begin
          if (exp_b.size() == 0) begin
            check("b_unexpected", 1'b1, 1'b0);
          end else begin
            be = exp_b.pop_front();
            check("bid", bid_o, be.id);
            check("bresp", bresp_o, be.resp);
          end
        end
      end
    end
  end

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [7:0] strb, input int nbeats,
                          input int last_pos, input logic [1:0] exp_resp);
    b_exp_t e;
    int     n;
    e.id = id; e.resp = exp_resp;
    exp_b.push_back(e);
    awvalid_i = 1'b1; awid_i = id; awaddr_i = addr; awlen_i = len;
    awsize_i = 3'd3; awburst_i = burst;
    n = 0;
    while (!awready_o && n < 50) begin tick(); n++; end
    check("awready", awready_o, 1'b1);
    tick();
    awvalid_i = 1'b0;
    check("wready_after_aw", wready_o, 1'b1);
    for (int i = 0; i < nbeats; i++) begin
      wvalid_i = 1'b1; wdata_i = wbuf[i]; wstrb_i = strb; wlast_i = (i == last_pos);
      n = 0;
      while (!wready_o && n < 50) begin tick(); n++; end
      tick();
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    check("bvalid_latency", bvalid_o, 1'b1);
    tick();
    check("awready_after_b", awready_o, 1'b1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic toggle);
    int   n;
    int   k;
    logic done;
    arvalid_i = 1'b1; arid_i = id; araddr_i = addr; arlen_i = len;
    arsize_i = 3'd3; arburst_i = burst;
    n = 0;
    while (!arready_o && n < 50) begin tick(); n++; end
    tick();
    arvalid_i = 1'b0;
    check("arready_busy", arready_o, 1'b0);
    n = 0;
    while (!rvalid_o && n < 50) begin tick(); n++; end
    check("rd_latency", 64'(n), 64'd2);
    k = 0;
    done = 1'b0;
    while (!done && k < 100) begin
      rready_i = toggle ? ((k % 2) == 0) : 1'b1;
      if (rvalid_o && rready_i && rlast_o) done = 1'b1;
      tick();
      k++;
    end
    rready_i = 1'b1;
    check("r_done", done, 1'b1);
    check("arready_after_last", arready_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1'b1;
    awvalid_i = 0; awid_i = 0; awaddr_i = 0; awlen_i = 0; awsize_i = 0; awburst_i = 0;
    wvalid_i = 0; wdata_i = 0; wstrb_i = 0; wlast_i = 0; bready_i = 1'b1;
    arvalid_i = 0; arid_i = 0; araddr_i = 0; arlen_i = 0; arsize_i = 0; arburst_i = 0;
    rready_i = 1'b1;
    tick();
    tick();
    check("rst_arready", arready_o, 1'b1);
    check("rst_awready", awready_o, 1'b1);
    check("rst_wready", wready_o, 1'b0);
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_bvalid", bvalid_o, 1'b0);
    check("rst_rlast", rlast_o, 1'b0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_rresp", rresp_o, 2'd0);
    check("rst_bresp", bresp_o, 2'd0);
    check("rst_rid", rid_o, 4'd0);
    check("rst_bid", bid_o, 4'd0);
    rst_i = 1'b0;
    tick();

    // Sentinel at word 0, used later to detect aliasing of an out-of-range write
    wbuf[0] = 64'hDEAD_BEEF_CAFE_F00D;
    do_write(4'd1, 32'h8000_0000, 8'd0, Incr, 8'hFF, 1, 0, 2'b00);

    wbuf[0] = 64'h1122_3344_5566_7788;
    do_write(4'd3, 32'h8000_0010, 8'd0, Incr, 8'hFF, 1, 0, 2'b00);
    push_r(4'd5, 64'h1122_3344_5566_7788, 2'b00, 1'b1);
    do_read(4'd5, 32'h8000_0010, 8'd0, Incr, 1'b0);

    wbuf[0] = A0; wbuf[1] = A1; wbuf[2] = A2; wbuf[3] = A3;
    do_write(4'd2, 32'h8000_0100, 8'd3, Incr, 8'hFF, 4, 3, 2'b00);
    push_r(4'd2, A0, 2'b00, 1'b0);
    push_r(4'd2, A1, 2'b00, 1'b0);
    push_r(4'd2, A2, 2'b00, 1'b0);
    push_r(4'd2, A3, 2'b00, 1'b1);
    do_read(4'd2, 32'h8000_0100, 8'd3, Incr, 1'b1);

    wbuf[0] = 64'hAAAA_AAAA_BBBB_BBBB;
    do_write(4'd3, 32'h8000_0010, 8'd0, Incr, 8'h0F, 1, 0, 2'b00);
    push_r(4'd3, 64'h1122_3344_BBBB_BBBB, 2'b00, 1'b1);
    do_read(4'd3, 32'h8000_0010, 8'd0, Incr, 1'b0);

    push_r(4'd6, 64'd0, 2'b11, 1'b1);
    do_read(4'd6, 32'h7FFF_FFF8, 8'd0, Incr, 1'b0);
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(4'd7, 32'h8000_8000, 8'd0, Incr, 8'hFF, 1, 0, 2'b11);
    push_r(4'd7, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 1'b1);
    do_read(4'd7, 32'h8000_0000, 8'd0, Incr, 1'b0);

    push_r(4'd8, 64'd0, 2'b10, 1'b0);
    push_r(4'd8, 64'd0, 2'b10, 1'b1);
    do_read(4'd8, 32'h8000_0100, 8'd1, Wrap, 1'b0);

    push_r(4'd10, A0, 2'b00, 1'b0);
    push_r(4'd10, A0, 2'b00, 1'b1);
    do_read(4'd10, 32'h8000_0100, 8'd1, Fixed, 1'b0);

    wbuf[0] = 64'h1234_5678_9ABC_DEF0;
    do_write(4'd9, 32'h8000_0200, 8'd1, Incr, 8'hFF, 1, 0, 2'b10);

    // Reset in the middle of a 4-beat read: only the first beat is ever accepted
    push_r(4'd4, A0, 2'b00, 1'b0);
    arvalid_i = 1'b1; arid_i = 4'd4; araddr_i = 32'h8000_0100; arlen_i = 8'd3;
    arsize_i = 3'd3; arburst_i = Incr;
    n = 0;
    while (!arready_o && n < 50) begin tick(); n++; end
    tick();
    arvalid_i = 1'b0;
    n = 0;
    while (!rvalid_o && n < 50) begin tick(); n++; end
    check("mid_rst_rvalid_seen", rvalid_o, 1'b1);
    tick();
    rst_i = 1'b1;
    tick();
    check("mid_rst_rvalid", rvalid_o, 1'b0);
    check("mid_rst_arready", arready_o, 1'b1);
    check("mid_rst_pending", 64'(exp_r.size()), 64'd0);
    exp_r.delete();
    rst_i = 1'b0;
    tick();

    push_r(4'd11, A1, 2'b00, 1'b1);
    do_read(4'd11, 32'h8000_0108, 8'd0, Incr, 1'b0);

    tick();
    check("r_queue_empty", 64'(exp_r.size()), 64'd0);
    check("b_queue_empty", 64'(exp_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
